// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants, default baud derivation and the
// transmitter sequencer state type. The PARITY state only exists when
// UART_FIFO_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int STOP_BITS            = 1;
    localparam int CLK_FREQ_HZ          = 50_000_000;
    localparam int BAUD_RATE            = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        START    = 3'd3,
        DATA     = 3'd4,
`ifdef UART_FIFO_TX_PARITY_EN
        PARITY   = 3'd5,
`endif
        STOP     = 3'd6
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer. Pulses tick on the last clock of every
// bit period while run is high; the count is parked at zero while run is low
// so the first bit of a frame always gets its full length.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST_COUNT);

    // Count clocks inside the current bit, restarting at every bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops one word from the upstream FIFO per request and sends
// its bytes least-significant first as back-to-back UART frames on txd.
// Frames are 8N1 by default, 8E1 when UART_FIFO_TX_PARITY_EN is defined.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifoEmpty,
    output logic                  readReq,
    input  logic                  readAck,
    input  logic [DATA_WIDTH-1:0] fifoData,
    output logic                  txd,
    output logic                  busy
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [2:0]            bit_idx;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [7:0]            cur_byte;
    logic                  run;
    logic                  tick;

    // The byte on the wire is always the low byte; later bytes are shifted down
    assign cur_byte = shift_reg[7:0];
    assign run      = (state != IDLE) && (state != REQ) && (state != WAIT_ACK);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .tick (tick)
    );

    // Sequencer: one pop handshake per word, then start/data/(parity)/stop per byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            readReq   <= 1'b0;
            busy      <= 1'b0;
            txd       <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoEmpty) begin
                        state   <= REQ;
                        readReq <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= WAIT_ACK;
                    readReq <= 1'b0;
                end
                WAIT_ACK: begin
                    if (readAck) begin
                        shift_reg <= fifoData;
                        byte_idx  <= '0;
                        state     <= START;
                        txd       <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= cur_byte[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA_BIT) begin
`ifdef UART_FIFO_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= ^cur_byte;
`else
                            state   <= STOP;
                            bit_idx <= '0;
                            txd     <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_FIFO_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        bit_idx <= '0;
                        txd     <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (bit_idx != LAST_STOP_BIT) begin
                            bit_idx <= bit_idx + 3'd1;
                        end else if (byte_idx < LAST_BYTE) begin
                            byte_idx  <= byte_idx + 1'b1;
                            shift_reg <= shift_reg >> 8;
                            bit_idx   <= '0;
                            state     <= START;
                            txd       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    readReq <= 1'b0;
                    busy    <= 1'b0;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule
